// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_pkg                                                    |
// | Brief   : Shared register-file widths and the write-request bundle.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int NREG   = 32;

   // One register-file write: enable, destination and data.
   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  wn;
      logic [DATA_W-1:0] d;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_scoreboard                                              |
// | Brief   : Busy-register bits for pending mul/div results and the     |
// |           decode-stage RAW/WAW stall lookup.                         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module wb_scoreboard
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             i_set_v,
   input  logic [REG_W-1:0] i_set_wn,
   input  logic             i_clr_v,
   input  logic [REG_W-1:0] i_clr_wn,
   input  logic [REG_W-1:0] i_rna,
   input  logic [REG_W-1:0] i_rnb,
   input  logic             i_id_we,
   input  logic [REG_W-1:0] i_id_wn,
   output logic             o_id_stall
);

   // r0 is hard-wired zero, so it never gets a busy bit.
   logic [NREG-1:1] r_busy;
   logic [NREG-1:1] w_set_mask;
   logic [NREG-1:1] w_clr_mask;
   logic [NREG-1:0] w_busy_full;

   // Decode the set/clear requests into one-hot masks; index 0 never matches.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      for (int i = 1; i < NREG; i++) begin
         w_set_mask[i] = i_set_v && (i_set_wn == REG_W'(i));
         w_clr_mask[i] = i_clr_v && (i_clr_wn == REG_W'(i));
      end
   end

   // Busy bits: clear first, then set, so a same-cycle issue wins.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      end
   end

   assign w_busy_full = {r_busy, 1'b0};

   // Stall on either source operand or on our own destination (WAW).
   always_comb begin
      o_id_stall = 1'b0;
      if (!clr) begin
         o_id_stall = w_busy_full[i_rna] | w_busy_full[i_rnb] |
                      (i_id_we & w_busy_full[i_id_wn]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_port_arbiter                                            |
// | Brief   : Shares the regfile write port between pipeline writeback   |
// |           and the mul/div unit via a one-entry result buffer with an |
// |           anti-starvation counter, plus a busy-register scoreboard.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module wb_port_arbiter
   import cpu_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              p_we,
   input  logic [REG_W-1:0]  p_wn,
   input  logic [DATA_W-1:0] p_d,
   input  logic              m_valid,
   input  logic [REG_W-1:0]  m_wn,
   input  logic [DATA_W-1:0] m_d,
   output logic              m_ready,
   input  logic              iss_valid,
   input  logic [REG_W-1:0]  iss_wn,
   input  logic [REG_W-1:0]  rna,
   input  logic [REG_W-1:0]  rnb,
   input  logic              id_we,
   input  logic [REG_W-1:0]  id_wn,
   output logic              id_stall,
   output logic              wb_stall,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_wn,
   output logic [DATA_W-1:0] rf_d
);

   localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] C_WAIT_MAX = CNT_W'(MAX_WAIT);

   wb_req_t          w_pipe;
   wb_req_t          w_mul;
   wb_req_t          w_rf;
   wb_req_t          r_hold;      // r_hold.we doubles as the buffer-valid flag
   logic [CNT_W-1:0] r_wait_cnt;

   logic w_p_req;
   logic w_force;
   logic w_grant_buf;
   logic w_grant_pipe;
   logic w_capture;

   assign w_pipe = '{we: p_we,    wn: p_wn, d: p_d};
   assign w_mul  = '{we: m_valid, wn: m_wn, d: m_d};

   // Priority: aged buffer, then pipeline, then buffer; nothing during reset.
   always_comb begin
      w_p_req      = w_pipe.we && (w_pipe.wn != '0);
      w_force      = r_hold.we && (r_wait_cnt == C_WAIT_MAX);
      w_grant_buf  = 1'b0;
      w_grant_pipe = 1'b0;
      if (!clr) begin
         if (w_force) begin
            w_grant_buf = 1'b1;
         end else if (w_p_req) begin
            w_grant_pipe = 1'b1;
         end else if (r_hold.we) begin
            w_grant_buf = 1'b1;
         end
      end
      wb_stall  = !clr && w_force && w_p_req;
      m_ready   = !clr && (!r_hold.we || w_grant_buf);
      w_capture = w_mul.we && m_ready;
      w_rf.we   = w_grant_buf || w_grant_pipe;
      w_rf.wn   = w_grant_buf ? r_hold.wn : w_pipe.wn;
      w_rf.d    = w_grant_buf ? r_hold.d  : w_pipe.d;
   end

   assign rf_we = w_rf.we;
   assign rf_wn = w_rf.wn;
   assign rf_d  = w_rf.d;

   // Result buffer: a capture (re)loads it, a grant alone empties it; r0 results are dropped.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_hold <= '0;
      end else if (w_capture) begin
         r_hold.we <= (w_mul.wn != '0);
         r_hold.wn <= w_mul.wn;
         r_hold.d  <= w_mul.d;
      end else if (w_grant_buf) begin
         r_hold.we <= 1'b0;
      end
   end

   // Counts lost arbitrations of the held result, saturating at the limit.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_wait_cnt <= '0;
      end else if (w_grant_buf || !r_hold.we) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != C_WAIT_MAX) begin
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
   end

   wb_scoreboard u_scoreboard (
      .clk        (clk),
      .clr        (clr),
      .i_set_v    (iss_valid),
      .i_set_wn   (iss_wn),
      .i_clr_v    (w_grant_buf),
      .i_clr_wn   (r_hold.wn),
      .i_rna      (rna),
      .i_rnb      (rnb),
      .i_id_we    (id_we),
      .i_id_wn    (id_wn),
      .o_id_stall (id_stall)
   );

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_wb_port_arbiter                                         |
// | Brief   : Vector table, directed corner sequences and random         |
// |           stimulus against a behavioural model of wb_port_arbiter.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_wb_port_arbiter;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        clr;
   logic        p_we, m_valid, iss_valid, id_we;
   logic [4:0]  p_wn, m_wn, iss_wn, rna, rnb, id_wn;
   logic [31:0] p_d, m_d;
   logic        m_ready, id_stall, wb_stall, rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;

   int n_pass  = 0;
   int n_total = 0;

   wb_port_arbiter #(.MAX_WAIT(MW)) dut (
      .clk(clk), .clr(clr),
      .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
      .m_valid(m_valid), .m_wn(m_wn), .m_d(m_d), .m_ready(m_ready),
      .iss_valid(iss_valid), .iss_wn(iss_wn),
      .rna(rna), .rnb(rnb), .id_we(id_we), .id_wn(id_wn),
      .id_stall(id_stall), .wb_stall(wb_stall),
      .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        clr, p_we;
      logic [4:0]  p_wn;
      logic [31:0] p_d;
      logic        m_valid;
      logic [4:0]  m_wn;
      logic [31:0] m_d;
      logic        iss_valid;
      logic [4:0]  iss_wn, rna, rnb;
      logic        id_we;
      logic [4:0]  id_wn;
      logic        e_we;
      logic [4:0]  e_wn;
      logic [31:0] e_d;
      logic        e_mr, e_ids, e_wbs;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cmp_out(input string tag, input logic e_we, input logic [31:0] e_wn,
                          input logic [31:0] e_d, input logic e_mr, input logic e_ids,
                          input logic e_wbs);
      chk({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, e_we});
      if (e_we) begin
         chk({tag, "_rf_wn"}, {27'd0, rf_wn}, e_wn);
         chk({tag, "_rf_d"}, rf_d, e_d);
      end
      chk({tag, "_m_ready"},  {31'd0, m_ready},  {31'd0, e_mr});
      chk({tag, "_id_stall"}, {31'd0, id_stall}, {31'd0, e_ids});
      chk({tag, "_wb_stall"}, {31'd0, wb_stall}, {31'd0, e_wbs});
   endtask

   task automatic check_out(input string tag, input logic e_we, input logic [31:0] e_wn,
                            input logic [31:0] e_d, input logic e_mr, input logic e_ids,
                            input logic e_wbs);
      @(negedge clk);
      cmp_out(tag, e_we, e_wn, e_d, e_mr, e_ids, e_wbs);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      p_we = 0; p_wn = 0; p_d = 0; m_valid = 0; m_wn = 0; m_d = 0;
      iss_valid = 0; iss_wn = 0; rna = 0; rnb = 0; id_we = 0; id_wn = 0;
   endtask

   task automatic do_reset();
      idle();
      clr = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 0;
   endtask

   // Behavioural model state
   bit          md_hold_v;
   logic [4:0]  md_hold_wn;
   logic [31:0] md_hold_d;
   bit          md_busy [32];
   int          md_losses;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        e_we, e_mr, e_ids, e_wbs, preq, aged, bufw, prev_stall;
      logic [4:0]  e_wn;
      logic [31:0] e_d;

      //                clr pwe pwn    pd          mv  mwn    md           iv  iwn    rna    rnb    idwe idwn  | we  wn     d            mr  ids wbs
      tbl[0]  = '{1'b1,1'b1,5'd3, 32'h11,      1'b1,5'd4, 32'h44,      1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,5'd3, 32'h11,      1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd3, 32'h11,      1'b1,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b1,5'd5, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd5, 32'hABCD,    1'b0,5'd0, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd0, 1'b0,5'd0, 1'b1,5'd5, 32'hABCD,    1'b1,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b1,5'd0, 32'h55,      1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'h77,      1'b1,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b0,1'b0};
      tbl[9]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b1,5'd10,5'd0, 5'd0, 1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b0,1'b0};
      tbl[10] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b1,5'd10,1'b0,5'd0, 32'h0,       1'b1,1'b1,1'b0};
      tbl[11] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd10,1'b0,5'd0, 1'b0,5'd0, 32'h0,       1'b1,1'b1,1'b0};
      tbl[12] = '{1'b0,1'b1,5'd31,32'hFFFFFFFF,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 1'b0,5'd0, 1'b1,5'd31,32'hFFFFFFFF,1'b1,1'b0,1'b0};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         clr = tbl[i].clr; p_we = tbl[i].p_we; p_wn = tbl[i].p_wn; p_d = tbl[i].p_d;
         m_valid = tbl[i].m_valid; m_wn = tbl[i].m_wn; m_d = tbl[i].m_d;
         iss_valid = tbl[i].iss_valid; iss_wn = tbl[i].iss_wn;
         rna = tbl[i].rna; rnb = tbl[i].rnb; id_we = tbl[i].id_we; id_wn = tbl[i].id_wn;
         check_out($sformatf("T%0d", i), tbl[i].e_we, {27'd0, tbl[i].e_wn}, tbl[i].e_d,
                   tbl[i].e_mr, tbl[i].e_ids, tbl[i].e_wbs);
      end

      // Starvation: buffered r7 loses MW times, then is forced out over a stalled WB.
      do_reset();
      m_valid = 1; m_wn = 7; m_d = 32'h700;
      check_out("A_cap", 0, 0, 0, 1, 0, 0);
      m_valid = 0;
      for (int i = 0; i < MW; i++) begin
         p_we = 1; p_wn = 5'(i + 1); p_d = 32'h100 + i;
         check_out($sformatf("A_pipe%0d", i), 1, i + 1, 32'h100 + i, 0, 0, 0);
      end
      p_wn = 5'd20; p_d = 32'h2020;
      check_out("A_force", 1, 7, 32'h700, 1, 0, 1);
      check_out("A_retry", 1, 20, 32'h2020, 1, 0, 0);

      // Reload: buffer drains r8 while r9 arrives in the same cycle.
      do_reset();
      m_valid = 1; m_wn = 8; m_d = 32'h800;
      check_out("B_cap", 0, 0, 0, 1, 0, 0);
      m_wn = 9; m_d = 32'h900;
      check_out("B_reload", 1, 8, 32'h800, 1, 0, 0);
      m_valid = 0;
      check_out("B_drain", 1, 9, 32'h900, 1, 0, 0);
      check_out("B_empty", 0, 0, 0, 1, 0, 0);

      // Set wins over clear on the same register.
      do_reset();
      iss_valid = 1; iss_wn = 6;
      check_out("C_iss", 0, 0, 0, 1, 0, 0);
      iss_valid = 0; m_valid = 1; m_wn = 6; m_d = 32'h600;
      check_out("C_cap", 0, 0, 0, 1, 0, 0);
      m_valid = 0; iss_valid = 1; iss_wn = 6;
      check_out("C_wr", 1, 6, 32'h600, 1, 0, 0);
      iss_valid = 0; rna = 6;
      check_out("C_busy", 0, 0, 0, 1, 1, 0);

      // Reset while a result is buffered and r12 is busy.
      do_reset();
      iss_valid = 1; iss_wn = 12;
      check_out("D_iss", 0, 0, 0, 1, 0, 0);
      iss_valid = 0; m_valid = 1; m_wn = 12; m_d = 32'hC00; p_we = 1; p_wn = 2; p_d = 32'h22;
      check_out("D_cap", 1, 2, 32'h22, 1, 0, 0);
      m_valid = 0; clr = 1; rna = 12;
      check_out("D_clr", 0, 0, 0, 0, 0, 0);
      clr = 0; p_we = 0;
      check_out("D_after", 0, 0, 0, 1, 0, 0);
      check_out("D_after2", 0, 0, 0, 1, 0, 0);

      // Random stimulus against the behavioural model.
      do_reset();
      md_hold_v = 0; md_hold_wn = 0; md_hold_d = 0; md_losses = 0;
      for (int r = 0; r < 32; r++) md_busy[r] = 0;
      prev_stall = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!prev_stall) begin
            p_we = ($urandom_range(9) < 7); p_wn = 5'($urandom_range(31)); p_d = $urandom;
         end
         clr = ($urandom_range(99) == 0);
         m_valid = ($urandom_range(9) < 4); m_wn = 5'($urandom_range(31)); m_d = $urandom;
         iss_valid = ($urandom_range(9) < 3); iss_wn = 5'($urandom_range(31));
         rna = 5'($urandom_range(31)); rnb = 5'($urandom_range(31));
         id_we = 1'($urandom_range(1)); id_wn = 5'($urandom_range(31));

         bufw = 0;
         if (clr) begin
            e_we = 0; e_wn = 0; e_d = 0; e_mr = 0; e_ids = 0; e_wbs = 0;
         end else begin
            preq  = p_we && (p_wn != 0);
            aged  = md_hold_v && (md_losses >= MW);
            bufw  = md_hold_v && (aged || !preq);
            e_we  = bufw || preq;
            e_wn  = bufw ? md_hold_wn : p_wn;
            e_d   = bufw ? md_hold_d  : p_d;
            e_wbs = aged && preq;
            e_mr  = !md_hold_v || bufw;
            e_ids = md_busy[rna] || md_busy[rnb] || (id_we && md_busy[id_wn]);
         end
         @(negedge clk);
         cmp_out($sformatf("R%0d", n), e_we, {27'd0, e_wn}, e_d, e_mr, e_ids, e_wbs);

         if (clr) begin
            md_hold_v = 0; md_losses = 0;
            for (int r = 0; r < 32; r++) md_busy[r] = 0;
         end else begin
            if (bufw) md_busy[md_hold_wn] = 0;
            if (iss_valid && iss_wn != 0) md_busy[iss_wn] = 1;
            if (bufw) begin
               md_hold_v = 0; md_losses = 0;
            end else if (md_hold_v) begin
               md_losses++;
            end
            if (m_valid && e_mr && m_wn != 0) begin
               md_hold_v = 1; md_hold_wn = m_wn; md_hold_d = m_d; md_losses = 0;
            end
         end
         prev_stall = e_wbs;
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline's writeback stage and the multi-cycle mul/div unit. It also keeps a busy-register scoreboard so the decode stage stalls on registers with a pending mul/div result. The block sits between WB/mul-div and the regfile write port (`we`/`wn`/`d`). It uses a one-entry result buffer and an anti-starvation counter.

## Interface
Parameters:
- `MAX_WAIT`, default 4: the maximum number of cycles a buffered mul/div result may lose arbitration; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `p_we`  in  1  pipeline WB write enable.
- `p_wn`  in  5  pipeline WB destination register.
- `p_d`  in  32  pipeline WB data.
- `m_valid`  in  1  mul/div result valid.
- `m_wn`  in  5  mul/div destination register.
- `m_d`  in  32  mul/div result.
- `m_ready`  out  1  arbiter accepts the mul/div result this cycle.
- `iss_valid`  in  1  decode issues a mul/div op this cycle.
- `iss_wn`  in  5  destination register of the issued mul/div op.
- `rna`, `rnb`  in  5 each  decode source registers.
- `id_we`, `id_wn`  in  1 / 5  decode instruction's own destination register.
- `id_stall`  out  1  decode must hold; combinational.
- `wb_stall`  out  1  pipeline WB write was refused; WB must hold for one cycle.
- `rf_we`, `rf_wn`, `rf_d`  out  1 / 5 / 32  regfile write port.

## Operation
State:
- `hold_v`, `hold_wn[4:0]`, `hold_d[31:0]`: the result buffer.
- `busy[31:1]`: scoreboard bits.
- `wait_cnt`: width `$clog2(MAX_WAIT+1)`.

Definitions:
- `p_req = p_we && p_wn != 0`.
- `force = hold_v && wait_cnt == MAX_WAIT`.

Grant, evaluated each cycle:
- If `force`: grant the buffer. If `p_req` is also set, assert `wb_stall=1`.
- Else if `p_req`: grant the pipeline.
- Else if `hold_v`: grant the buffer.
- Else: `rf_we=0`.

Port driving:
- `rf_wn`/`rf_d` come from the granted source.
- `rf_we=1` only on a grant.

Buffer:
- `m_ready = !hold_v || buffer_granted`.
- When `m_valid && m_ready`, capture `m_wn`/`m_d` and set `hold_v=1`. A result with `m_wn==0` is accepted and discarded (`hold_v` stays 0).
- A buffer grant without a new capture clears `hold_v`.
- A grant and a capture in the same cycle reload the buffer: `hold_v` stays 1 and `wait_cnt` becomes 0.

Wait counter:
- Becomes 0 on any buffer grant or when `!hold_v`.
- Otherwise increments while `hold_v` is set and the buffer loses arbitration.
- Saturates at `MAX_WAIT`.

Scoreboard:
- Set: `iss_valid && iss_wn!=0` sets `busy[iss_wn]`.
- Clear: a buffer grant clears `busy[hold_wn]`.
- Same register set and cleared in the same cycle: set wins.
- `busy[0]` does not exist and always reads 0.

Decode stall:
- `id_stall = busy[rna] | busy[rnb] | (id_we && busy[id_wn])`.
- The third term covers WAW hazards.
- Decode never issues while `id_stall` is high. Therefore at most one pending mul/div result exists per register.

Reset behaviour:
- While `clr` is high: `rf_we=0`, `m_ready=0`, `id_stall=0`, `wb_stall=0`.
- At the clocked edge, reset sets `hold_v=0`, `busy=0` and `wait_cnt=0`.
- A result in flight during reset is lost; the mul/div unit is reset by the same `clr`.

## Timing
- Pipeline write: 0-cycle latency; the `p_*` inputs pass combinationally to `rf_*`.
- Mul/div result: accepted at edge N and written to the regfile no earlier than cycle N+1. Worst case N+1+`MAX_WAIT`.
- `busy` clears at the edge that performs the write. `id_stall` drops in the following cycle.
- `wb_stall`: the pipeline presents the same `p_*` values in the next cycle. That write is guaranteed to be granted, because the counter is 0 after a forced grant.
- `m_ready` has combinational dependence on `p_we`; the mul/div unit must not feed `m_ready` back combinationally into `m_valid`.

## Structure
- Shared package `cpu_pkg`:
  - `REG_W=5`, `DATA_W=32`, `NREG=32`.
  - Typedef `wb_req_t {we, wn, d}` for the `p_*`, `m_*` and `rf_*` bundles.
- Sub-module `wb_scoreboard`:
  - Holds the `busy` vector, set/clear logic and the three-way `id_stall` lookup.
  - The arbiter, buffer and counter live in the top module.

## Test plan
- Reset, then `p_we=1`, `p_wn=3`, `p_d=0x11` -> same cycle `rf_we=1`, `rf_wn=3`, `rf_d=0x11`. Check `m_ready=0` during `clr` and `m_ready=1` after it.
- Issue `iss_wn=5`, then `rna=5` -> `id_stall=1`. Mul/div result `m_wn=5`, `m_d=0xABCD` accepted at edge N with `p_we=0` -> written at N+1, `id_stall=0` at N+2.
- Buffer holding `wn=7`, `p_we=1` every cycle, `MAX_WAIT=4` -> four pipeline writes, then a buffer write with `wb_stall=1`. The held pipeline write is granted on the next cycle.
- Buffer granted while `m_valid=1`, `m_wn=9` -> reload in the same cycle: `hold_v` stays 1 and no result is dropped.
- `iss_wn=6` issued in the same cycle the buffer writes `wn=6` -> `busy[6]` remains 1. Also `m_wn=0` and `iss_wn=0` -> no regfile write and no busy bit.
- `clr` asserted while `hold_v=1` and `busy[12]=1` -> next cycle `hold_v=0`, `id_stall=0` for `rna=12`, and no `rf_we` pulse.
